// File: rtl/countdown_pkg.sv
// countdown_pkg: seven-segment patterns and scan slot encoding shared by the display scanner
package countdown_pkg;
    typedef enum logic {TENS = 1'b0, ONES = 1'b1} slot_t;
    // Index 0 is the rightmost entry, so DIGITS[n] is the pattern for digit n ({dp,g,f,e,d,c,b,a}).
    localparam logic [9:0][7:0] DIGITS = {8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D,
                                          8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F};
    localparam logic [7:0] DASH = 8'h40;
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-high segment pattern, non-BCD codes shown as a dash
module seg7_decode
    import countdown_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [7:0] pat
);
    assign pat = (bcd < 4'd10) ? DIGITS[bcd] : DASH;
endmodule

// File: rtl/display_scan.sv
// display_scan: two-digit multiplexed 7-segment scanner with frame-synchronous
// digit update, leading-zero blanking and frame-counted blinking
module display_scan
    import countdown_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blink_en,
    output logic [1:0] seg,
    output logic [7:0] bs,
    output logic       frame
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [PW-1:0] pre;
    slot_t         slot;
    logic [3:0]    sh_t, sh_o, d_t, d_o;
    logic          pend;
    logic [BW-1:0] bcnt;
    logic          bph;
    logic          tc, tick, bwrap, dark;
    logic [3:0]    dig;
    logic [7:0]    pat;

    assign tc    = pre == PW'(SCAN_DIV - 1);
    assign tick  = tc && slot == ONES;
    assign bwrap = bcnt == BW'(BLINK_DIV - 1);
    assign dig   = (slot == TENS) ? d_t : d_o;
    assign dark  = (blink_en && bph) || (slot == TENS && d_t == 4'd0);

    seg7_decode u_dec (.bcd(dig), .pat(pat));

    always_ff @(posedge clock) begin
        if (reset) begin
            pre   <= '0;
            slot  <= TENS;
            sh_t  <= '0;
            sh_o  <= '0;
            d_t   <= '0;
            d_o   <= '0;
            pend  <= 1'b0;
            bcnt  <= '0;
            bph   <= 1'b0;
            seg   <= '0;
            bs    <= '0;
            frame <= 1'b0;
        end else begin
            pre   <= tc ? '0 : pre + 1'b1;
            slot  <= tc ? ((slot == TENS) ? ONES : TENS) : slot;
            frame <= tick;
            // A load on the boundary cycle still sees the old shadow here and re-arms pend.
            if (tick && pend) {d_t, d_o} <= {sh_t, sh_o};
            if (load) {sh_t, sh_o, pend} <= {tens, ones, 1'b1};
            else if (tick) pend <= 1'b0;
            if (!blink_en) {bcnt, bph} <= '0;
            else if (tick) begin
                bcnt <= bwrap ? '0 : bcnt + 1'b1;
                bph  <= bph ^ bwrap;
            end
            seg <= dark ? 2'b00 : ((slot == TENS) ? 2'b10 : 2'b01);
            bs  <= dark ? 8'h00 : pat;
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: directed table plus corner-case sequences for display_scan (SCAN_DIV=4, BLINK_DIV=2)
module tb_display_scan;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] tens = '0;
    logic [3:0] ones = '0;
    logic       blink_en = 1'b0;
    logic [1:0] seg;
    logic [7:0] bs;
    logic       frame;
    int         total = 0;
    int         passed = 0;

    typedef struct {
        logic [3:0] t, o;
        logic [1:0] st, so;
        logic [7:0] bt, bo;
    } vec_t;

    display_scan #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clock(clock), .reset(reset), .load(load), .tens(tens), .ones(ones),
        .blink_en(blink_en), .seg(seg), .bs(bs), .frame(frame)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic step();
        @(negedge clock);
        load = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] t, input logic [3:0] o);
        tens = t;
        ones = o;
        load = 1'b1;
        step();
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (!frame && n < 40);
        chk("frame_wait", {7'b0, frame}, 8'h01);
    endtask

    // Starts on the sample where frame is high (or just after reset); covers one full frame.
    task automatic check_frame(input logic [1:0] st, input logic [7:0] bt,
                               input logic [1:0] so, input logic [7:0] bo);
        for (int i = 0; i < 8; i++) begin
            step();
            chk(i < 4 ? "seg_tens" : "seg_ones", {6'b0, seg}, i < 4 ? {6'b0, st} : {6'b0, so});
            chk(i < 4 ? "bs_tens" : "bs_ones", bs, i < 4 ? bt : bo);
            chk("frame", {7'b0, frame}, (i == 7) ? 8'h01 : 8'h00);
        end
    endtask

    vec_t vt[7];

    initial begin
        vt[0] = '{4'd2, 4'd7,  2'b10, 2'b01, 8'h5B, 8'h07};
        vt[1] = '{4'd0, 4'd5,  2'b00, 2'b01, 8'h00, 8'h6D};
        vt[2] = '{4'd2, 4'd12, 2'b10, 2'b01, 8'h5B, 8'h40};
        vt[3] = '{4'd9, 4'd8,  2'b10, 2'b01, 8'h6F, 8'h7F};
        vt[4] = '{4'd1, 4'd0,  2'b10, 2'b01, 8'h06, 8'h3F};
        vt[5] = '{4'd15, 4'd3, 2'b10, 2'b01, 8'h40, 8'h4F};
        vt[6] = '{4'd6, 4'd4,  2'b10, 2'b01, 8'h7D, 8'h66};

        step();
        step();
        reset = 1'b0;
        chk("rst_seg", {6'b0, seg}, 8'h00);
        chk("rst_bs", bs, 8'h00);
        chk("rst_frame", {7'b0, frame}, 8'h00);
        check_frame(2'b00, 8'h00, 2'b01, 8'h3F);

        foreach (vt[k]) begin
            step();
            do_load(vt[k].t, vt[k].o);
            wait_frame();
            check_frame(vt[k].st, vt[k].bt, vt[k].so, vt[k].bo);
        end

        step();
        do_load(4'd1, 4'd3);
        do_load(4'd1, 4'd4);
        wait_frame();
        check_frame(2'b10, 8'h06, 2'b01, 8'h66);

        tens = 4'd4;
        ones = 4'd2;
        load = 1'b1;
        check_frame(2'b10, 8'h06, 2'b01, 8'h66);
        check_frame(2'b10, 8'h66, 2'b01, 8'h5B);

        step();
        do_load(4'd0, 4'd0);
        wait_frame();
        check_frame(2'b00, 8'h00, 2'b01, 8'h3F);
        blink_en = 1'b1;
        check_frame(2'b00, 8'h00, 2'b01, 8'h3F);
        check_frame(2'b00, 8'h00, 2'b01, 8'h3F);
        check_frame(2'b00, 8'h00, 2'b00, 8'h00);
        check_frame(2'b00, 8'h00, 2'b00, 8'h00);
        check_frame(2'b00, 8'h00, 2'b01, 8'h3F);
        check_frame(2'b00, 8'h00, 2'b01, 8'h3F);
        repeat (5) step();
        chk("blink_dark_seg", {6'b0, seg}, 8'h00);
        chk("blink_dark_bs", bs, 8'h00);
        blink_en = 1'b0;
        step();
        chk("blink_restore_seg", {6'b0, seg}, 8'h01);
        chk("blink_restore_bs", bs, 8'h3F);

        wait_frame();
        step();
        do_load(4'd5, 4'd5);
        wait_frame();
        check_frame(2'b10, 8'h6D, 2'b01, 8'h6D);
        repeat (5) step();
        do_load(4'd8, 4'd8);
        reset = 1'b1;
        do_load(4'd9, 4'd9);
        reset = 1'b0;
        chk("midrst_seg", {6'b0, seg}, 8'h00);
        chk("midrst_bs", bs, 8'h00);
        chk("midrst_frame", {7'b0, frame}, 8'h00);
        check_frame(2'b00, 8'h00, 2'b01, 8'h3F);
        check_frame(2'b00, 8'h00, 2'b01, 8'h3F);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
